// File: rtl/wb_regfile.sv
// Writeback stage register file: selects the writeback value, commits it to a
// 2**ADDR_WIDTH entry GPR file, and serves two ID read ports with write-through bypass.
module wb_regfile #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  RegWrite_i,
  input  logic                  MemtoReg_i,
  input  logic [DATA_WIDTH-1:0] dataMem_data_i,
  input  logic [DATA_WIDTH-1:0] ALU_result_i,
  input  logic [ADDR_WIDTH-1:0] RDaddr_i,
  input  logic [ADDR_WIDTH-1:0] RSaddr_i,
  input  logic [ADDR_WIDTH-1:0] RTaddr_i,
  output logic [DATA_WIDTH-1:0] RSdata_o,
  output logic [DATA_WIDTH-1:0] RTdata_o,
  output logic [DATA_WIDTH-1:0] WBdata_o,
  output logic                  WBvalid_o,
  output logic [CNT_WIDTH-1:0]  wb_count_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  w_wr_en;

  assign WBdata_o   = MemtoReg_i ? dataMem_data_i : ALU_result_i;
  // RegWrite_i gates the compare so X addresses cannot leak in when idle
  assign w_wr_en    = RegWrite_i && (RDaddr_i != '0);
  assign WBvalid_o  = w_wr_en;
  assign wb_count_o = r_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
      r_count <= '0;
    end else if (w_wr_en) begin
      r_regs[RDaddr_i] <= WBdata_o;
      r_count          <= r_count + CNT_WIDTH'(1);
    end
  end

  // Read port 1: r0 and reset force zero, otherwise bypass or stored value
  always_comb begin
    RSdata_o = '0;
    if (!rst_i && (RSaddr_i != '0)) begin
      if (w_wr_en && (RSaddr_i == RDaddr_i)) begin
        RSdata_o = WBdata_o;
      end else begin
        RSdata_o = r_regs[RSaddr_i];
      end
    end
  end

  always_comb begin
    RTdata_o = '0;
    if (!rst_i && (RTaddr_i != '0)) begin
      if (w_wr_en && (RTaddr_i == RDaddr_i)) begin
        RTdata_o = WBdata_o;
      end else begin
        RTdata_o = r_regs[RTaddr_i];
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: vector table plus reset, X-idle and counter-wrap sequences.
module tb_wb_regfile;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          RegWrite_i;
  logic          MemtoReg_i;
  logic [DW-1:0] dataMem_data_i;
  logic [DW-1:0] ALU_result_i;
  logic [AW-1:0] RDaddr_i;
  logic [AW-1:0] RSaddr_i;
  logic [AW-1:0] RTaddr_i;
  logic [DW-1:0] RSdata_o;
  logic [DW-1:0] RTdata_o;
  logic [DW-1:0] WBdata_o;
  logic          WBvalid_o;
  logic [CW-1:0] wb_count_o;

  int n_checks = 0;
  int n_fail   = 0;

  wb_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .RegWrite_i     (RegWrite_i),
    .MemtoReg_i     (MemtoReg_i),
    .dataMem_data_i (dataMem_data_i),
    .ALU_result_i   (ALU_result_i),
    .RDaddr_i       (RDaddr_i),
    .RSaddr_i       (RSaddr_i),
    .RTaddr_i       (RTaddr_i),
    .RSdata_o       (RSdata_o),
    .RTdata_o       (RTdata_o),
    .WBdata_o       (WBdata_o),
    .WBvalid_o      (WBvalid_o),
    .wb_count_o     (wb_count_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic          we;
    logic          m2r;
    logic [DW-1:0] dmem;
    logic [DW-1:0] alu;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [DW-1:0] e_rs;
    logic [DW-1:0] e_rt;
    logic [DW-1:0] e_wb;
    logic          e_valid;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic m2r, input logic [DW-1:0] dmem,
                       input logic [DW-1:0] alu, input logic [AW-1:0] rd,
                       input logic [AW-1:0] rs, input logic [AW-1:0] rt);
    RegWrite_i     = we;
    MemtoReg_i     = m2r;
    dataMem_data_i = dmem;
    ALU_result_i   = alu;
    RDaddr_i       = rd;
    RSaddr_i       = rs;
    RTaddr_i       = rt;
  endtask

  initial begin
    // we m2r dmem alu rd rs rt | e_rs e_rt e_wb e_valid e_cnt(after edge)
    vecs[0]  = '{1'b1, 1'b0, 32'h0,        32'h12345678, 5'd8, 5'd0, 5'd8, 32'h0,        32'h12345678, 32'h12345678, 1'b1, 4'd1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd8, 5'd1, 5'd8, 32'h0,        32'h12345678, 32'h0,        1'b0, 4'd1};
    vecs[2]  = '{1'b1, 1'b1, 32'hCAFEF00D, 32'h1,        5'd3, 5'd3, 5'd8, 32'hCAFEF00D, 32'h12345678, 32'hCAFEF00D, 1'b1, 4'd2};
    vecs[3]  = '{1'b0, 1'b1, 32'h0,        32'h5,        5'd3, 5'd3, 5'd3, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0,        1'b0, 4'd2};
    vecs[4]  = '{1'b1, 1'b0, 32'h0,        32'h11,       5'd9, 5'd8, 5'd3, 32'h12345678, 32'hCAFEF00D, 32'h11,       1'b1, 4'd3};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,        32'h22,       5'd9, 5'd9, 5'd9, 32'h22,       32'h22,       32'h22,       1'b1, 4'd4};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd9, 5'd9, 5'd0, 32'h22,       32'h0,        32'h0,        1'b0, 4'd4};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,        32'hFFFFFFFF, 5'd0, 5'd0, 5'd9, 32'h0,        32'h22,       32'hFFFFFFFF, 1'b0, 4'd4};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        1'b0, 4'd4};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,        32'hDEADBEEF, 5'd5, 5'd5, 5'd9, 32'hDEADBEEF, 32'h22,       32'hDEADBEEF, 1'b1, 4'd5};
    vecs[10] = '{1'b0, 1'b1, 32'h0BADF00D, 32'h0,        5'd31,5'd5, 5'd31,32'hDEADBEEF, 32'h0,        32'h0BADF00D, 1'b0, 4'd5};

    // Reset state: writes blocked, reads zero without bypass, WB path still live
    rst_i = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 32'hA5, 5'd3, 5'd3, 5'd3);
    #1;
    check("rst_rs_no_bypass", RSdata_o, 32'h0);
    check("rst_wbdata",       WBdata_o, 32'hA5);
    check("rst_wbvalid",      {31'h0, WBvalid_o}, 32'h1);
    @(posedge clk_i); #1;
    check("rst_count",        {28'h0, wb_count_o}, 32'h0);
    check("rst_write_block",  RTdata_o, 32'h0);
    @(negedge clk_i);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd0);
    rst_i = 1'b0;
    #1;
    check("post_rst_r3", RSdata_o, 32'h0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk_i);
      drive(vecs[i].we, vecs[i].m2r, vecs[i].dmem, vecs[i].alu, vecs[i].rd, vecs[i].rs, vecs[i].rt);
      #1;
      check($sformatf("v%0d_rs", i),    RSdata_o, vecs[i].e_rs);
      check($sformatf("v%0d_rt", i),    RTdata_o, vecs[i].e_rt);
      check($sformatf("v%0d_wb", i),    WBdata_o, vecs[i].e_wb);
      check($sformatf("v%0d_valid", i), {31'h0, WBvalid_o}, {31'h0, vecs[i].e_valid});
      @(posedge clk_i); #1;
      check($sformatf("v%0d_cnt", i),   {28'h0, wb_count_o}, {28'h0, vecs[i].e_cnt});
    end

    // Idle cycle with X data/address must not disturb state or counter
    @(negedge clk_i);
    drive(1'b0, 1'b0, 'x, 'x, 'x, 5'd9, 5'd8);
    @(posedge clk_i); #1;
    check("xidle_r9",  RSdata_o, 32'h22);
    check("xidle_r8",  RTdata_o, 32'h12345678);
    check("xidle_cnt", {28'h0, wb_count_o}, 32'h5);

    // Async reset asserted mid-cycle clears the file immediately
    @(negedge clk_i);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd8);
    #1;
    check("pre_async_r5", RSdata_o, 32'hDEADBEEF);
    #1;
    rst_i = 1'b1;
    #1;
    check("async_r5",  RSdata_o, 32'h0);
    check("async_r8",  RTdata_o, 32'h0);
    check("async_cnt", {28'h0, wb_count_o}, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h99, 5'd5, 5'd5, 5'd5);
    @(posedge clk_i); #1;
    check("rst_held_cnt", {28'h0, wb_count_o}, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 32'h77, 5'd5, 5'd0, 5'd0);
    @(posedge clk_i); #1;
    check("first_wr_cnt", {28'h0, wb_count_o}, 32'h1);
    @(negedge clk_i);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd9);
    #1;
    check("first_wr_r5", RSdata_o, 32'h77);
    check("cleared_r9",  RTdata_o, 32'h0);

    // Counter wrap at CNT_WIDTH=4: 17 commits to r1 from a zero count
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    rst_i = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk_i);
      drive(1'b1, 1'b0, 32'h0, DW'(k), 5'd1, 5'd0, 5'd0);
      @(posedge clk_i); #1;
      if (k >= 14) check($sformatf("wrap_cnt_%0d", k), {28'h0, wb_count_o}, DW'(k % 16));
    end
    @(negedge clk_i);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd0);
    #1;
    check("wrap_r1", RSdata_o, 32'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
